// File: rtl/deser_frame_controller.sv
// Frame controller for a serial deserializer word.
// Synchronizes the asynchronous active-low frame select, steers an external
// enabled shift register and captures whole frames for a ready/ack consumer.
// Short, long and overrun frames are reported and counted.
module deser_frame_controller #(
   parameter int FRAME_BITS  = 14,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  ss,
   input  logic                  bit_strobe,
   input  logic                  ack,
   input  logic [FRAME_BITS-1:0] shift_q,
   output logic                  shift_en,
   output logic                  shift_clr,
   output logic [FRAME_BITS-1:0] data_out,
   output logic                  ready,
   output logic                  frame_err,
   output logic                  overrun,
   output logic [7:0]            err_count,
   output logic [1:0]            state
);

   // Counter holds FRAME_BITS itself so a full frame never wraps to zero.
   localparam int CNT_W = $clog2(FRAME_BITS + 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(FRAME_BITS);

   typedef enum logic [1:0] {
      S_IDLE    = 2'b00,
      S_CAPTURE = 2'b01,
      S_DONE    = 2'b10,
      S_ERR     = 2'b11
   } state_t;

   state_t                 st;
   logic [SYNC_STAGES-1:0] sync_ff;
   logic                   hist;
   logic                   sync_s;
   logic                   fall;
   logic                   rise;
   logic                   accept;
   logic [CNT_W-1:0]       bit_count;
   logic                   too_long;

   // Bring ss into the clock domain; the history flop gives edge detection.
   // NOTE: these flops reset to 1 (ss idle level) so reset release alone
   // cannot fake a rise; a low ss after release reads as a fresh fall.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_ff <= '1;
         hist    <= 1'b1;
      end else begin
         sync_ff[0] <= ss;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_ff[i] <= sync_ff[i-1];
         end
         hist <= sync_ff[SYNC_STAGES-1];
      end
   end

   assign sync_s = sync_ff[SYNC_STAGES-1];
   assign fall   = hist & ~sync_s;
   assign rise   = ~hist & sync_s;

   // A strobe counts only while capturing and never in the closing-edge cycle.
   assign accept    = (st == S_CAPTURE) & bit_strobe & ~rise;
   assign shift_en  = accept & (bit_count < FULL);
   // Clear is combinational so the register is empty at the first CAPTURE edge.
   assign shift_clr = fall & ((st == S_IDLE) | ((st == S_DONE) & ack));
   assign overrun   = fall & (st == S_DONE) & ~ack;
   assign ready     = (st == S_DONE);
   assign frame_err = (st == S_ERR);
   assign state     = st;

   // Frame FSM with bit counting, capture and error accounting.
   // NOTE: all state here uses non-blocking assignment so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         st        <= S_IDLE;
         bit_count <= '0;
         too_long  <= 1'b0;
         data_out  <= '0;
         err_count <= '0;
      end else begin
         case (st)
            S_IDLE: begin
               if (fall) begin
                  st        <= S_CAPTURE;
                  bit_count <= '0;
                  too_long  <= 1'b0;
               end
            end
            S_CAPTURE: begin
               if (rise) begin
                  if (bit_count == FULL && !too_long) begin
                     data_out <= shift_q;
                     st       <= S_DONE;
                  end else begin
                     st <= S_ERR;
                  end
               end else if (accept) begin
                  if (bit_count < FULL) begin
                     bit_count <= bit_count + 1'b1;
                  end else begin
                     too_long <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               // A fall without ack is an overrun: the frame is dropped here.
               if (ack) begin
                  if (fall) begin
                     st        <= S_CAPTURE;
                     bit_count <= '0;
                     too_long  <= 1'b0;
                  end else begin
                     st <= S_IDLE;
                  end
               end
            end
            S_ERR: begin
               if (err_count != 8'hFF) begin
                  err_count <= err_count + 1'b1;
               end
               st <= S_IDLE;
            end
            default: st <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_deser_frame_controller.sv
// Self-checking bench for deser_frame_controller: directed frames, a model of
// the external shift register, and a scoreboard of expected captured words.
module tb_deser_frame_controller;

   localparam int FB = 14;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          ss = 1'b1;
   logic          bit_strobe = 1'b0;
   logic          ack = 1'b0;
   logic          din = 1'b0;
   logic [FB-1:0] shift_q = '0;
   logic          shift_en;
   logic          shift_clr;
   logic [FB-1:0] data_out;
   logic          ready;
   logic          frame_err;
   logic          overrun;
   logic [7:0]    err_count;
   logic [1:0]    state;

   int checks = 0;
   int failures = 0;
   int se_cnt = 0;
   int fe_cnt = 0;
   int ov_cnt = 0;
   int rdy_cnt = 0;
   logic ready_d = 1'b0;
   logic [FB-1:0] exp_q[$];

   deser_frame_controller #(.FRAME_BITS(FB), .SYNC_STAGES(2)) dut (
      .clock     (clock),
      .reset     (reset),
      .ss        (ss),
      .bit_strobe(bit_strobe),
      .ack       (ack),
      .shift_q   (shift_q),
      .shift_en  (shift_en),
      .shift_clr (shift_clr),
      .data_out  (data_out),
      .ready     (ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .err_count (err_count),
      .state     (state)
   );

   always #5 clock = ~clock;

   // External enabled shift register, MSB first.
   always @(posedge clock) begin
      if (shift_clr) shift_q <= '0;
      else if (shift_en) shift_q <= {shift_q[FB-2:0], din};
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pulse counters and scoreboard compare on each new ready.
   always @(negedge clock) begin
      if (!reset) begin
         if (shift_en) se_cnt++;
         if (frame_err) fe_cnt++;
         if (overrun) ov_cnt++;
         if (ready && !ready_d) begin
            rdy_cnt++;
            if (exp_q.size() == 0) begin
               check("unexpected_ready", 32'(data_out), 32'hFFFF_FFFF);
            end else begin
               check("scoreboard_data", 32'(data_out), 32'(exp_q.pop_front()));
            end
         end
         ready_d <= ready;
      end else begin
         ready_d <= 1'b0;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic start_frame();
      ss = 1'b0;
      tick(3);
   endtask

   task automatic end_frame();
      ss = 1'b1;
      tick(3);
   endtask

   task automatic strobes(input logic [15:0] w, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         bit_strobe = 1'b1;
         din = w[i];
         tick(1);
         bit_strobe = 1'b0;
         tick(1);
      end
   endtask

   task automatic do_ack();
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int se0, fe0, ov0, rc0;
      // Reset state
      tick(3);
      check("rst_state", 32'(state), 32'h0);
      check("rst_ready", 32'(ready), 32'h0);
      check("rst_data", 32'(data_out), 32'h0);
      check("rst_errcnt", 32'(err_count), 32'h0);
      check("rst_pulses", 32'({shift_en, shift_clr, frame_err, overrun}), 32'h0);
      reset = 1'b0;
      tick(2);

      // Nominal frame 0x2A5C
      exp_q.push_back(14'h2A5C);
      se0 = se_cnt;
      start_frame();
      check("nom_capture", 32'(state), 32'h1);
      strobes(16'h2A5C, 14);
      ss = 1'b1;
      tick(2);
      check("nom_rise_not_ready", 32'(ready), 32'h0);
      tick(1);
      check("nom_ready", 32'(ready), 32'h1);
      check("nom_data", 32'(data_out), 32'h2A5C);
      check("nom_shift_cnt", 32'(se_cnt - se0), 32'd14);
      do_ack();
      check("nom_ack_ready", 32'(ready), 32'h0);
      check("nom_ack_idle", 32'(state), 32'h0);

      // Short frame: 13 strobes
      fe0 = fe_cnt; rc0 = rdy_cnt;
      start_frame();
      strobes(16'h1ABC, 13);
      end_frame();
      check("short_err_state", 32'(state), 32'h3);
      tick(1);
      check("short_idle", 32'(state), 32'h0);
      check("short_fe_pulses", 32'(fe_cnt - fe0), 32'd1);
      check("short_errcnt", 32'(err_count), 32'd1);
      check("short_no_ready", 32'(rdy_cnt - rc0), 32'd0);

      // Long frame: 15 strobes
      fe0 = fe_cnt; se0 = se_cnt;
      start_frame();
      strobes(16'h7FFF, 15);
      end_frame();
      tick(1);
      check("long_shift_cnt", 32'(se_cnt - se0), 32'd14);
      check("long_fe_pulses", 32'(fe_cnt - fe0), 32'd1);
      check("long_errcnt", 32'(err_count), 32'd2);
      check("long_idle", 32'(state), 32'h0);

      // 14 strobes plus a strobe coincident with rise: still a good frame
      exp_q.push_back(14'h0F0F);
      se0 = se_cnt;
      start_frame();
      strobes(16'h0F0F, 14);
      ss = 1'b1;
      tick(2);
      bit_strobe = 1'b1; din = 1'b1;
      #1;
      check("rise_strobe_no_shift", 32'(shift_en), 32'h0);
      tick(1);
      bit_strobe = 1'b0;
      check("rise_strobe_done", 32'(state), 32'h2);
      check("rise_strobe_data", 32'(data_out), 32'h0F0F);
      check("rise_strobe_shift_cnt", 32'(se_cnt - se0), 32'd14);
      do_ack();

      // 13 strobes plus a coincident strobe: still short
      start_frame();
      strobes(16'h0AAA, 13);
      ss = 1'b1;
      tick(2);
      bit_strobe = 1'b1;
      tick(1);
      bit_strobe = 1'b0;
      check("rise_strobe_short_err", 32'(state), 32'h3);
      tick(1);
      check("rise_strobe_errcnt", 32'(err_count), 32'd3);

      // Overrun: second frame while ready unacknowledged
      exp_q.push_back(14'h2A5C);
      start_frame();
      strobes(16'h2A5C, 14);
      end_frame();
      check("ovr_first_ready", 32'(ready), 32'h1);
      ov0 = ov_cnt; se0 = se_cnt;
      start_frame();
      strobes(16'h1555, 14);
      end_frame();
      check("ovr_pulses", 32'(ov_cnt - ov0), 32'd1);
      check("ovr_no_shift", 32'(se_cnt - se0), 32'd0);
      check("ovr_data_kept", 32'(data_out), 32'h2A5C);
      check("ovr_still_done", 32'(state), 32'h2);

      // Ack coincident with fall: straight to CAPTURE, clear, no overrun
      exp_q.push_back(14'h1555);
      ss = 1'b0;
      tick(2);
      ack = 1'b1;
      #1;
      check("ackfall_clr", 32'(shift_clr), 32'h1);
      check("ackfall_no_ovr", 32'(overrun), 32'h0);
      tick(1);
      ack = 1'b0;
      check("ackfall_capture", 32'(state), 32'h1);
      check("ackfall_ovr_total", 32'(ov_cnt - ov0), 32'd1);
      strobes(16'h1555, 14);
      end_frame();
      check("ackfall_data", 32'(data_out), 32'h1555);
      do_ack();

      // Reset mid-frame after 7 strobes
      start_frame();
      strobes(16'h3C3C, 7);
      reset = 1'b1;
      #1;
      check("midrst_state", 32'(state), 32'h0);
      check("midrst_outs", 32'({ready, shift_en, shift_clr, frame_err, overrun}), 32'h0);
      check("midrst_data", 32'(data_out), 32'h0);
      check("midrst_errcnt", 32'(err_count), 32'h0);
      ss = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(3);
      check("postrst_idle", 32'(state), 32'h0);
      exp_q.push_back(14'h3C3C);
      start_frame();
      strobes(16'h3C3C, 14);
      end_frame();
      check("postrst_data", 32'(data_out), 32'h3C3C);
      do_ack();

      // 256 empty frames saturate err_count
      fe0 = fe_cnt;
      for (int k = 0; k < 256; k++) begin
         start_frame();
         end_frame();
         tick(1);
      end
      check("sat_fe_pulses", 32'(fe_cnt - fe0), 32'd256);
      check("sat_errcnt", 32'(err_count), 32'd255);
      check("sat_idle", 32'(state), 32'h0);

      tick(3);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
